// File: rtl/jesd204b_byte_aligner.sv
// jesd204b_byte_aligner: soft comma (K28.5) byte aligner for one JESD204B lane.
// Finds the comma, locks a byte offset, and rotates the raw 4-byte words so the
// comma lands in lane 0. Build option JESD_BYTE_ALIGN_STATS_EN enables the
// saturating realign_cnt statistic; without it realign_cnt reads 0.
//
// state  | meaning
// SEARCH | no candidate offset yet, waiting for any comma
// CHECK  | candidate offset taken, counting commas seen at that same offset
// LOCKED | offset confirmed; held until a comma shows up elsewhere
module jesd204b_byte_aligner #(
  parameter logic [7:0]  COMMA_BYTE = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic        link_clk,
  input  logic        link_reset_b,
  input  logic [31:0] raw_data,
  input  logic [3:0]  raw_datak,
  input  logic        pattern_align_en,
  output logic [31:0] rx_parallel_data,
  output logic [3:0]  rx_datak,
  output logic [3:0]  pattern_detect,
  output logic [1:0]  byte_offset,
  output logic        locked,
  output logic [15:0] realign_cnt
);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

  state_t      state_q, state_d;
  logic [1:0]  offset_q, offset_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        locked_q, locked_d;
  logic [31:0] prev_q;
  logic [3:0]  prevk_q;
  logic [31:0] data_q, win_data;
  logic [3:0]  datak_q, win_k;
  logic [3:0]  detect_q, win_detect;
  logic [3:0]  comma_hit;
  logic        any_hit;
  logic [1:0]  first_p;
  logic [63:0] cat_data;
  logic [7:0]  cat_k;

  // Comma detection on the raw word; scanning downward makes the lowest byte win.
  always_comb begin
    comma_hit = '0;
    first_p   = 2'd0;
    for (int p = 0; p < 4; p++) begin
      comma_hit[p] = (raw_data[8*p +: 8] == COMMA_BYTE) && raw_datak[p];
    end
    for (int p = 3; p >= 0; p--) begin
      if (comma_hit[p]) first_p = 2'(p);
    end
    any_hit = |comma_hit;
  end

  // Rotation window over {current, previous} words selected by the live offset.
  always_comb begin
    cat_data = {raw_data, prev_q};
    cat_k    = {raw_datak, prevk_q};
    win_data = cat_data[31:0];
    win_k    = cat_k[3:0];
    case (offset_q)
      2'd0: begin win_data = cat_data[31:0];  win_k = cat_k[3:0]; end
      2'd1: begin win_data = cat_data[39:8];  win_k = cat_k[4:1]; end
      2'd2: begin win_data = cat_data[47:16]; win_k = cat_k[5:2]; end
      default: begin win_data = cat_data[55:24]; win_k = cat_k[6:3]; end
    endcase
    for (int i = 0; i < 4; i++) begin
      win_detect[i] = (win_data[8*i +: 8] == COMMA_BYTE) && win_k[i];
    end
  end

  // Alignment state machine next-state logic.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    cnt_d    = cnt_q;
    locked_d = locked_q;
    case (state_q)
      SEARCH: begin
        if (pattern_align_en && any_hit) begin
          offset_d = first_p;
          cnt_d    = 4'd1;
          if (LOCK_CNT == 4'd1) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
          end else begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (!pattern_align_en) begin
          state_d = SEARCH;
          cnt_d   = 4'd0;
        end else if (any_hit && (first_p == offset_q)) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == LOCK_CNT) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
          end
        end else if (any_hit) begin
          offset_d = first_p;
          cnt_d    = 4'd1;
        end
      end
      LOCKED: begin
        if (pattern_align_en && any_hit && (first_p != offset_q)) begin
          offset_d = first_p;
          cnt_d    = 4'd1;
          locked_d = 1'b0;
          state_d  = CHECK;
        end
      end
      default: begin
        state_d  = SEARCH;
        cnt_d    = 4'd0;
        locked_d = 1'b0;
      end
    endcase
  end

  // State machine and datapath registers.
  always_ff @(posedge link_clk or negedge link_reset_b) begin
    if (!link_reset_b) begin
      state_q  <= SEARCH;
      offset_q <= 2'd0;
      cnt_q    <= 4'd0;
      locked_q <= 1'b0;
      prev_q   <= 32'h0;
      prevk_q  <= 4'h0;
      data_q   <= 32'h0;
      datak_q  <= 4'h0;
      detect_q <= 4'h0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      prev_q   <= raw_data;
      prevk_q  <= raw_datak;
      data_q   <= win_data;
      datak_q  <= win_k;
      detect_q <= win_detect;
    end
  end

`ifdef JESD_BYTE_ALIGN_STATS_EN
  logic [15:0] realign_cnt_q, realign_cnt_d;
  logic        realign_evt;

  // Count LOCKED->CHECK realigns, saturating at all-ones.
  always_comb begin
    realign_evt   = (state_q == LOCKED) && pattern_align_en && any_hit &&
                    (first_p != offset_q);
    realign_cnt_d = realign_cnt_q;
    if (realign_evt && (realign_cnt_q != 16'hFFFF)) realign_cnt_d = realign_cnt_q + 16'd1;
  end

  // Statistic register, cleared only by reset.
  always_ff @(posedge link_clk or negedge link_reset_b) begin
    if (!link_reset_b) realign_cnt_q <= 16'h0;
    else               realign_cnt_q <= realign_cnt_d;
  end

  assign realign_cnt = realign_cnt_q;
`else
  assign realign_cnt = 16'h0;
`endif

  assign rx_parallel_data = data_q;
  assign rx_datak         = datak_q;
  assign pattern_detect   = detect_q;
  assign byte_offset      = offset_q;
  assign locked           = locked_q;

endmodule

// File: tb/tb_jesd204b_byte_aligner.sv
// Directed bench for jesd204b_byte_aligner with hand-computed expectations.
module tb_jesd204b_byte_aligner;

  logic        link_clk;
  logic        link_reset_b;
  logic [31:0] raw_data;
  logic [3:0]  raw_datak;
  logic        pattern_align_en;
  logic [31:0] rx_parallel_data;
  logic [3:0]  rx_datak;
  logic [3:0]  pattern_detect;
  logic [1:0]  byte_offset;
  logic        locked;
  logic [15:0] realign_cnt;

  int total = 0;
  int bad   = 0;

`ifdef JESD_BYTE_ALIGN_STATS_EN
  localparam logic [15:0] EXP_RA1 = 16'd1;
`else
  localparam logic [15:0] EXP_RA1 = 16'd0;
`endif

  jesd204b_byte_aligner dut (
    .link_clk         (link_clk),
    .link_reset_b     (link_reset_b),
    .raw_data         (raw_data),
    .raw_datak        (raw_datak),
    .pattern_align_en (pattern_align_en),
    .rx_parallel_data (rx_parallel_data),
    .rx_datak         (rx_datak),
    .pattern_detect   (pattern_detect),
    .byte_offset      (byte_offset),
    .locked           (locked),
    .realign_cnt      (realign_cnt)
  );

  initial link_clk = 1'b0;
  always #5 link_clk = ~link_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one raw word, clock it in, sample 1 time unit after the edge.
  task automatic step(input logic [31:0] d, input logic [3:0] k);
    raw_data  = d;
    raw_datak = k;
    @(posedge link_clk);
    #1;
  endtask

  task automatic pulse_reset();
    link_reset_b = 1'b0;
    #2;
    link_reset_b = 1'b1;
  endtask

  initial begin
    link_reset_b     = 1'b0;
    raw_data         = 32'h0;
    raw_datak        = 4'h0;
    pattern_align_en = 1'b1;
    #23;
    link_reset_b = 1'b1;
    @(posedge link_clk);
    #1;

    // 1: reset state
    step(32'h0, 4'h0);
    chk("rst_data",   rx_parallel_data, 32'h0);
    chk("rst_k",      32'(rx_datak), 32'h0);
    chk("rst_pd",     32'(pattern_detect), 32'h0);
    chk("rst_off",    32'(byte_offset), 32'h0);
    chk("rst_lock",   32'(locked), 32'h0);
    chk("rst_ra",     32'(realign_cnt), 32'h0);

    // 2: comma at byte 2, lock after 4 words
    step(32'h11BC2233, 4'h4);
    chk("t2_off1",    32'(byte_offset), 32'h2);
    chk("t2_lock1",   32'(locked), 32'h0);
    chk("t2_data1",   rx_parallel_data, 32'h0);
    step(32'h11BC2233, 4'h4);
    chk("t2_data2",   rx_parallel_data, 32'h223311BC);
    chk("t2_pd2",     32'(pattern_detect), 32'h1);
    chk("t2_k2",      32'(rx_datak), 32'h1);
    step(32'h11BC2233, 4'h4);
    chk("t2_lock3",   32'(locked), 32'h0);
    step(32'h11BC2233, 4'h4);
    chk("t2_lock4",   32'(locked), 32'h1);
    chk("t2_off4",    32'(byte_offset), 32'h2);
    step(32'h44556677, 4'h0);
    chk("t2_data5",   rx_parallel_data, 32'h667711BC);
    chk("t2_pd5",     32'(pattern_detect), 32'h1);
    chk("t2_lock5",   32'(locked), 32'h1);
    step(32'h44556677, 4'h0);
    chk("t2_data6",   rx_parallel_data, 32'h66774455);
    chk("t2_pd6",     32'(pattern_detect), 32'h0);

    // 3: align disabled, comma elsewhere is ignored
    pattern_align_en = 1'b0;
    step(32'h000000BC, 4'h1);
    step(32'h000000BC, 4'h1);
    chk("t3_off",     32'(byte_offset), 32'h2);
    chk("t3_lock",    32'(locked), 32'h1);
    chk("t3_ra",      32'(realign_cnt), 32'h0);
    chk("t3_data",    rx_parallel_data, 32'h00BC0000);
    chk("t3_pd",      32'(pattern_detect), 32'h4);

    // 4: realign to byte 3 then relock
    pattern_align_en = 1'b1;
    step(32'hBC000000, 4'h8);
    chk("t4_lock0",   32'(locked), 32'h0);
    chk("t4_off",     32'(byte_offset), 32'h3);
    chk("t4_ra",      32'(realign_cnt), 32'(EXP_RA1));
    step(32'hBC000000, 4'h8);
    step(32'hBC000000, 4'h8);
    chk("t4_lock2",   32'(locked), 32'h0);
    chk("t4_data",    rx_parallel_data, 32'h000000BC);
    chk("t4_pd",      32'(pattern_detect), 32'h1);
    step(32'hBC000000, 4'h8);
    chk("t4_lock3",   32'(locked), 32'h1);
    chk("t4_ra2",     32'(realign_cnt), 32'(EXP_RA1));

    // 5: comma moves while in CHECK with two counted
    pulse_reset();
    chk("t5_ra_rst",  32'(realign_cnt), 32'h0);
    step(32'h00BC0000, 4'h4);
    step(32'h00BC0000, 4'h4);
    chk("t5_off2",    32'(byte_offset), 32'h2);
    step(32'h0000BC00, 4'h2);
    chk("t5_off1",    32'(byte_offset), 32'h1);
    chk("t5_lockA",   32'(locked), 32'h0);
    step(32'h0000BC00, 4'h2);
    step(32'h0000BC00, 4'h2);
    chk("t5_lockB",   32'(locked), 32'h0);
    step(32'h0000BC00, 4'h2);
    chk("t5_lockC",   32'(locked), 32'h1);
    chk("t5_data",    rx_parallel_data, 32'h000000BC);
    chk("t5_pd",      32'(pattern_detect), 32'h1);

    // 6: two commas in one word, then reset mid-CHECK
    pulse_reset();
    step(32'hBC00BC00, 4'hA);
    chk("t6_off",     32'(byte_offset), 32'h1);
    step(32'hBC00BC00, 4'hA);
    chk("t6_data_pre", rx_parallel_data, 32'h00BC00BC);
    link_reset_b = 1'b0;
    #1;
    chk("t6_rdata",   rx_parallel_data, 32'h0);
    chk("t6_rpd",     32'(pattern_detect), 32'h0);
    chk("t6_roff",    32'(byte_offset), 32'h0);
    chk("t6_rlock",   32'(locked), 32'h0);
    #1;
    link_reset_b = 1'b1;
    step(32'h0, 4'h0);
    chk("t6_off0",    32'(byte_offset), 32'h0);

    // CHECK with align disabled falls back to SEARCH, offset held, count restarts
    step(32'hBC000000, 4'h8);
    pattern_align_en = 1'b0;
    step(32'h0, 4'h0);
    chk("t6_hold_off", 32'(byte_offset), 32'h3);
    pattern_align_en = 1'b1;
    step(32'hBC000000, 4'h8);
    step(32'hBC000000, 4'h8);
    step(32'hBC000000, 4'h8);
    chk("t6_relockA", 32'(locked), 32'h0);
    step(32'hBC000000, 4'h8);
    chk("t6_relockB", 32'(locked), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
